// File: rtl/pause_ctrl.sv
// pause_ctrl: merges NUM_REQ pause-request channels into one core halt/drain handshake.
// Single-step support is compiled in only when PAUSE_STEP_EN is defined.
`timescale 1ns/1ps
module pause_ctrl #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned SYNC_MASK     = 1,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_bootDone,
  input  logic [NUM_REQ-1:0] i_pauseReq,
  input  logic               i_coreIdle,
  input  logic               i_stepReq,
  output logic               o_haltReq,
  output logic               o_isPaused,
  output logic               o_isBooted,
  output logic [NUM_REQ-1:0] o_reqSrc,
  output logic               o_drainErr
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    PAUSED = 3'd3,
`ifdef PAUSE_STEP_EN
    STEP   = 3'd5,
`endif
    RESUME = 3'd4
  } state_t;

  state_t             state, stateNext;
  logic [CNT_W-1:0]   drainCnt;
  logic [NUM_REQ-1:0] reqS;
  logic               anyReq;
  logic               timeoutHit;

  logic               haltReqNext;
  logic               isPausedNext;
  logic               isBootedNext;
  logic [NUM_REQ-1:0] reqSrcNext;
  logic               drainErrNext;
  logic               holdSrc;

  // Per-channel request conditioning: full synchroniser or a single register.
  for (genvar i = 0; i < NUM_REQ; i++) begin : gReq
    if (SYNC_MASK[i]) begin : gSync
      logic [SYNC_STAGES-1:0] chain;
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) chain <= '0;
        else         chain <= {chain[SYNC_STAGES-2:0], i_pauseReq[i]};
      end
      assign reqS[i] = chain[SYNC_STAGES-1];
    end else begin : gReg
      logic flop;
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) flop <= 1'b0;
        else         flop <= i_pauseReq[i];
      end
      assign reqS[i] = flop;
    end
  end

  assign anyReq     = |reqS;
  assign timeoutHit = (drainCnt == CNT_LAST);

  // State register and drain counter; the counter restarts on every DRAIN entry.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= BOOT;
      drainCnt <= '0;
    end else begin
      state    <= stateNext;
      drainCnt <= (state == DRAIN && stateNext == DRAIN) ? drainCnt + CNT_W'(1) : '0;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      BOOT:    if (i_bootDone) stateNext = anyReq ? DRAIN : RUN;
      RUN:     if (anyReq) stateNext = DRAIN;
      DRAIN:   if (i_coreIdle || timeoutHit) stateNext = PAUSED;
      PAUSED: begin
        if (!anyReq) stateNext = RESUME;
`ifdef PAUSE_STEP_EN
        else if (i_stepReq) stateNext = STEP;
`endif
      end
      RESUME:  stateNext = anyReq ? DRAIN : RUN;
`ifdef PAUSE_STEP_EN
      STEP:    stateNext = DRAIN;
`endif
      default: stateNext = BOOT;
    endcase
  end

`ifndef PAUSE_STEP_EN
  logic unusedStep;
  assign unusedStep = i_stepReq;
`endif

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    haltReqNext  = (stateNext == DRAIN) || (stateNext == PAUSED);
    isPausedNext = (stateNext == PAUSED);
    isBootedNext = o_isBooted || (stateNext != BOOT);
    drainErrNext = o_drainErr || (state == DRAIN && !i_coreIdle && timeoutHit);
    holdSrc      = haltReqNext;
`ifdef PAUSE_STEP_EN
    holdSrc      = holdSrc || (stateNext == STEP);
`endif
    // o_reqSrc is zero outside a pause, so OR-ing also covers the initial load.
    reqSrcNext   = holdSrc ? (o_reqSrc | reqS) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_haltReq  <= 1'b0;
      o_isPaused <= 1'b0;
      o_isBooted <= 1'b0;
      o_reqSrc   <= '0;
      o_drainErr <= 1'b0;
    end else begin
      o_haltReq  <= haltReqNext;
      o_isPaused <= isPausedNext;
      o_isBooted <= isBootedNext;
      o_reqSrc   <= reqSrcNext;
      o_drainErr <= drainErrNext;
    end
  end

endmodule

// File: tb/tb_pause_ctrl.sv
// Self-checking bench for pause_ctrl (NUM_REQ=2, ch0 synchronised, ch1 registered once).
// Expected output vectors are queued as stimulus is driven and popped after each clock edge.
`timescale 1ns/1ps
module tb_pause_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_bootDone;
  logic [1:0] i_pauseReq;
  logic       i_coreIdle;
  logic       i_stepReq;
  logic       o_haltReq;
  logic       o_isPaused;
  logic       o_isBooted;
  logic [1:0] o_reqSrc;
  logic       o_drainErr;

  logic [5:0] obsV;
  logic [5:0] expQ[$];
  int         checks = 0;
  int         errors = 0;

  pause_ctrl #(
    .NUM_REQ(2), .SYNC_MASK(1), .SYNC_STAGES(2), .DRAIN_TIMEOUT(16)
  ) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_bootDone (i_bootDone),
    .i_pauseReq (i_pauseReq),
    .i_coreIdle (i_coreIdle),
    .i_stepReq  (i_stepReq),
    .o_haltReq  (o_haltReq),
    .o_isPaused (o_isPaused),
    .o_isBooted (o_isBooted),
    .o_reqSrc   (o_reqSrc),
    .o_drainErr (o_drainErr)
  );

  always #5 i_clk = ~i_clk;

  // {halt, paused, booted, reqSrc[1:0], drainErr}
  assign obsV = {o_haltReq, o_isPaused, o_isBooted, o_reqSrc, o_drainErr};

  // Stimulus vector: {bootDone, stepReq, coreIdle, pauseReq[1:0]}
  task automatic drive(input logic [4:0] v);
    {i_bootDone, i_stepReq, i_coreIdle, i_pauseReq} = v;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] expV;
    i_rstn = 1'b0;
    drive(5'b00000);
    expQ.push_back(6'b000000);
    repeat (2) tick();
    expV = expQ.pop_front();
    checks++;
    if (obsV !== expV) begin
      errors++;
      $display("FAIL reset: got %b expected %b", obsV, expV);
    end
    i_rstn = 1'b1;
  endtask

  task automatic test_boot_gate();
    logic [4:0] s[$];
    logic [5:0] e[$];
    logic [5:0] expV;
    for (int k = 0; k < 20; k++) begin
      s.push_back(5'b00001);
      e.push_back(6'b000000);
    end
    s.push_back(5'b10001); e.push_back(6'b101010);
    s.push_back(5'b10101); e.push_back(6'b111010);
    s.push_back(5'b10000); e.push_back(6'b111010);
    s.push_back(5'b10000); e.push_back(6'b111010);
    s.push_back(5'b10000); e.push_back(6'b001000);
    s.push_back(5'b10000); e.push_back(6'b001000);
    foreach (s[k]) begin
      drive(s[k]);
      expQ.push_back(e[k]);
      tick();
      expV = expQ.pop_front();
      checks++;
      if (obsV !== expV) begin
        errors++;
        $display("FAIL boot_gate step %0d: got %b expected %b", k, obsV, expV);
      end
    end
  endtask

  task automatic test_sync_latency();
    logic [4:0] s[$];
    logic [5:0] e[$];
    logic [5:0] expV;
    s = '{5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001,
          5'b10101, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
    e = '{6'b001000, 6'b001000, 6'b101010, 6'b101010, 6'b101010,
          6'b111010, 6'b111010, 6'b111010, 6'b001000, 6'b001000};
    foreach (s[k]) begin
      drive(s[k]);
      expQ.push_back(e[k]);
      tick();
      expV = expQ.pop_front();
      checks++;
      if (obsV !== expV) begin
        errors++;
        $display("FAIL sync_latency step %0d: got %b expected %b", k, obsV, expV);
      end
    end
  endtask

  task automatic test_drain_timeout();
    logic [4:0] s[$];
    logic [5:0] e[$];
    logic [5:0] expV;
    s.push_back(5'b10010); e.push_back(6'b001000);
    for (int k = 0; k < 16; k++) begin
      s.push_back(5'b10010);
      e.push_back(6'b101100);
    end
    s.push_back(5'b10010); e.push_back(6'b111101);
    s.push_back(5'b10000); e.push_back(6'b111101);
    s.push_back(5'b10000); e.push_back(6'b001001);
    s.push_back(5'b10000); e.push_back(6'b001001);
    foreach (s[k]) begin
      drive(s[k]);
      expQ.push_back(e[k]);
      tick();
      expV = expQ.pop_front();
      checks++;
      if (obsV !== expV) begin
        errors++;
        $display("FAIL drain_timeout step %0d: got %b expected %b", k, obsV, expV);
      end
    end
    // Only reset clears the sticky error.
    @(negedge i_clk);
    i_rstn = 1'b0;
    expQ.push_back(6'b000000);
    #1;
    expV = expQ.pop_front();
    checks++;
    if (obsV !== expV) begin
      errors++;
      $display("FAIL drain_err_reset: got %b expected %b", obsV, expV);
    end
    tick();
    i_rstn = 1'b1;
    drive(5'b10000);
    expQ.push_back(6'b001000);
    tick();
    expV = expQ.pop_front();
    checks++;
    if (obsV !== expV) begin
      errors++;
      $display("FAIL reboot_after_timeout: got %b expected %b", obsV, expV);
    end
  endtask

  task automatic test_multi_src();
    logic [4:0] s[$];
    logic [5:0] e[$];
    logic [5:0] expV;
    s = '{5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10011, 5'b10011,
          5'b10010, 5'b10010, 5'b10010, 5'b10001, 5'b10001, 5'b10001,
          5'b10100, 5'b10000, 5'b10000, 5'b10000};
    e = '{6'b001000, 6'b001000, 6'b101010, 6'b111010, 6'b111010, 6'b111110,
          6'b111110, 6'b111110, 6'b111110, 6'b111110, 6'b001000, 6'b101010,
          6'b111010, 6'b111010, 6'b001000, 6'b001000};
    foreach (s[k]) begin
      drive(s[k]);
      expQ.push_back(e[k]);
      tick();
      expV = expQ.pop_front();
      checks++;
      if (obsV !== expV) begin
        errors++;
        $display("FAIL multi_src step %0d: got %b expected %b", k, obsV, expV);
      end
    end
  endtask

  task automatic test_step();
    logic [4:0] s[$];
    logic [5:0] e[$];
    logic [5:0] expV;
    s = '{5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b11001, 5'b10001,
          5'b10101, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
`ifdef PAUSE_STEP_EN
    e = '{6'b001000, 6'b001000, 6'b101010, 6'b111010, 6'b001010, 6'b101010,
          6'b111010, 6'b111010, 6'b111010, 6'b001000, 6'b001000};
`else
    e = '{6'b001000, 6'b001000, 6'b101010, 6'b111010, 6'b111010, 6'b111010,
          6'b111010, 6'b111010, 6'b111010, 6'b001000, 6'b001000};
`endif
    foreach (s[k]) begin
      drive(s[k]);
      expQ.push_back(e[k]);
      tick();
      expV = expQ.pop_front();
      checks++;
      if (obsV !== expV) begin
        errors++;
        $display("FAIL step step %0d: got %b expected %b", k, obsV, expV);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] s[$];
    logic [5:0] e[$];
    logic [5:0] expV;
    s = '{5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10001};
    e = '{6'b001000, 6'b001000, 6'b101010, 6'b111010, 6'b111010};
    foreach (s[k]) begin
      drive(s[k]);
      expQ.push_back(e[k]);
      tick();
      expV = expQ.pop_front();
      checks++;
      if (obsV !== expV) begin
        errors++;
        $display("FAIL pre_reset step %0d: got %b expected %b", k, obsV, expV);
      end
    end
    // Mid-cycle reset: outputs must clear before the next clock edge.
    @(negedge i_clk);
    drive(5'b00001);
    i_rstn = 1'b0;
    expQ.push_back(6'b000000);
    #1;
    expV = expQ.pop_front();
    checks++;
    if (obsV !== expV) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", obsV, expV);
    end
    tick();
    i_rstn = 1'b1;
    // Back in BOOT: the held request must be ignored until boot completes.
    s = '{5'b00001, 5'b00001, 5'b00001, 5'b10001};
    e = '{6'b000000, 6'b000000, 6'b000000, 6'b101010};
    foreach (s[k]) begin
      drive(s[k]);
      expQ.push_back(e[k]);
      tick();
      expV = expQ.pop_front();
      checks++;
      if (obsV !== expV) begin
        errors++;
        $display("FAIL post_reset_boot step %0d: got %b expected %b", k, obsV, expV);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot_gate();
    test_sync_latency();
    test_drain_timeout();
    test_multi_src();
    test_step();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
